detect_trigger_ctrl: RTL and testbench

- Parametrised successor of the white/black detection controller.
- Watches the VGA pixel stream and brackets one "detection window" per bright-to-dark event. The window opens on a run of bright pixels and closes on a run of dark pixels.
- Adds hysteresis thresholds, consecutive-pixel debounce, a pixel-valid qualifier, an enable, a window timeout and single-cycle event pulses.
- Sits between the VGA capture path and the detection datapath, which consumes start_detect/finish_detect.

---
 rtl/detect_trigger_ctrl.sv | 163 ++++++++++++++++
 tb/tb_detect_trigger_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/detect_trigger_ctrl.sv
// rtl/detect_trigger_ctrl.sv - bright/dark detection window controller with hysteresis, debounce and timeout
//
// Purpose:
//   Watches a qualified RGB pixel stream and brackets one detection window per
//   bright-to-dark event. A run of DEBOUNCE bright pixels opens the window
//   (WAIT -> DETECT); a run of DEBOUNCE dark pixels closes it (DETECT -> WAIT).
//   An optional cycle timeout also closes the window. en=0 forces IDLE.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en                       controller enable (0 forces IDLE, highest priority)
//   pix_valid                vga_r/g/b carry a pixel this cycle
//   vga_r, vga_g, vga_b      colour channels, PIX_W bits each
//   start_detect             level, high while in DETECT
//   finish_detect            level, high while in WAIT
//   start_pulse              one cycle on entry to DETECT
//   finish_pulse             one cycle on DETECT -> WAIT via dark run
//   timeout_pulse            one cycle on DETECT -> WAIT via timeout
//   state_o                  0=IDLE, 1=WAIT, 2=DETECT
module detect_trigger_ctrl #(
  parameter int PIX_W    = 8,
  parameter int HI_THR   = 175,
  parameter int LO_THR   = 31,
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] vga_r,
  input  logic [PIX_W-1:0] vga_g,
  input  logic [PIX_W-1:0] vga_b,
  output logic             start_detect,
  output logic             finish_detect,
  output logic             start_pulse,
  output logic             finish_pulse,
  output logic             timeout_pulse,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_DETECT = 2'd2
  } state_t;

  localparam int DW = $clog2(DEBOUNCE + 1);
  // A zero TIMEOUT would give a zero-width counter; keep one bit that is never used.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [PIX_W-1:0] HI      = PIX_W'(HI_THR);
  localparam logic [PIX_W-1:0] LO      = PIX_W'(LO_THR);
  localparam logic [DW-1:0]    DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0]    DB_MAX  = DW'(DEBOUNCE);
  localparam logic [TW-1:0]    TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic             TO_EN   = (TIMEOUT != 0);

  state_t          state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            start_pulse_q, start_pulse_d;
  logic            finish_pulse_q, finish_pulse_d;
  logic            timeout_pulse_q, timeout_pulse_d;

  logic bright, dark;
  logic target, run_done;
  logic [DW-1:0] cnt_next;

  assign bright = pix_valid & (vga_r > HI) & (vga_g > HI) & (vga_b > HI);
  assign dark   = pix_valid & (vga_r < LO) & (vga_g < LO) & (vga_b < LO);

  always_comb begin
    target   = 1'b0;
    cnt_next = cnt_q;
    // The class that advances the run depends on which edge of the window we await.
    if (state_q == S_WAIT) begin
      target = bright;
    end else if (state_q == S_DETECT) begin
      target = dark;
    end
    if (pix_valid) begin
      if (target) begin
        cnt_next = (cnt_q == DB_MAX) ? cnt_q : cnt_q + DW'(1);
      end else begin
        cnt_next = '0;
      end
    end
    run_done = target & (cnt_q == DB_LAST);
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_next;
    tcnt_d          = '0;
    start_pulse_d   = 1'b0;
    finish_pulse_d  = 1'b0;
    timeout_pulse_d = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (run_done) begin
            state_d       = S_DETECT;
            cnt_d         = '0;
            start_pulse_d = 1'b1;
          end
        end
        S_DETECT: begin
          // Dark completion outranks a coincident timeout.
          if (run_done) begin
            state_d        = S_WAIT;
            cnt_d          = '0;
            finish_pulse_d = 1'b1;
          end else if (TO_EN && (tcnt_q == TO_LAST)) begin
            state_d         = S_WAIT;
            cnt_d           = '0;
            timeout_pulse_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      tcnt_q          <= '0;
      start_pulse_q   <= 1'b0;
      finish_pulse_q  <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      tcnt_q          <= tcnt_d;
      start_pulse_q   <= start_pulse_d;
      finish_pulse_q  <= finish_pulse_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign start_detect  = (state_q == S_DETECT);
  assign finish_detect = (state_q == S_WAIT);
  assign start_pulse   = start_pulse_q;
  assign finish_pulse  = finish_pulse_q;
  assign timeout_pulse = timeout_pulse_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_detect_trigger_ctrl.sv
// tb/tb_detect_trigger_ctrl.sv - self-checking bench for detect_trigger_ctrl
module tb_detect_trigger_ctrl;

  localparam int DB = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] vga_r = '0, vga_g = '0, vga_b = '0;
  logic       start_detect, finish_detect, start_pulse, finish_pulse, timeout_pulse;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  detect_trigger_ctrl #(
    .PIX_W(8), .HI_THR(175), .LO_THR(31), .DEBOUNCE(DB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_valid(pix_valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .start_detect(start_detect), .finish_detect(finish_detect),
    .start_pulse(start_pulse), .finish_pulse(finish_pulse),
    .timeout_pulse(timeout_pulse), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference: mode 0/1/2, length of the current qualifying run, cycles spent in the window.
  int m_mode = 0;
  int m_run = 0;
  int m_age = 0;
  bit m_sp = 0, m_fp = 0, m_tp = 0;

  always @(posedge clk) begin
    bit is_bright, is_dark;
    is_bright = pix_valid && vga_r > 175 && vga_g > 175 && vga_b > 175;
    is_dark   = pix_valid && vga_r < 31 && vga_g < 31 && vga_b < 31;
    m_sp = 0; m_fp = 0; m_tp = 0;
    if (rst || !en) begin
      m_mode = 0; m_run = 0; m_age = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_run = 0;
    end else if (m_mode == 1) begin
      if (pix_valid) m_run = is_bright ? m_run + 1 : 0;
      if (m_run == DB) begin
        m_mode = 2; m_sp = 1; m_run = 0; m_age = 0;
      end
    end else begin
      m_age = m_age + 1;
      if (pix_valid) m_run = is_dark ? m_run + 1 : 0;
      if (m_run == DB) begin
        m_mode = 1; m_fp = 1; m_run = 0;
      end else if (m_age == TO) begin
        m_mode = 1; m_tp = 1; m_run = 0;
      end
    end
    #1;
    if (chk_on) begin
      cmp("state_o", int'(state_o), m_mode);
      cmp("start_detect", int'(start_detect), int'(m_mode == 2));
      cmp("finish_detect", int'(finish_detect), int'(m_mode == 1));
      cmp("start_pulse", int'(start_pulse), int'(m_sp));
      cmp("finish_pulse", int'(finish_pulse), int'(m_fp));
      cmp("timeout_pulse", int'(timeout_pulse), int'(m_tp));
    end
  end

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input bit v, input int r, input int g, input int b);
    @(negedge clk);
    pix_valid = v;
    vga_r = 8'(r); vga_g = 8'(g); vga_b = 8'(b);
    @(posedge clk);
    #2;
  endtask

  task automatic rep(input int n, input bit v, input int p);
    for (int i = 0; i < n; i++) drive(v, p, p, p);
  endtask

  function automatic int pick_level(input int cls);
    case (cls)
      0: return $urandom_range(255, 176);
      1: return $urandom_range(30, 0);
      2: return 175;
      3: return 31;
      default: return $urandom_range(255, 0);
    endcase
  endfunction

  initial begin
    // Reset
    rst = 1; en = 0;
    drive(0, 0, 0, 0);
    chk_on = 1;
    drive(0, 0, 0, 0);
    lit("reset state", int'(state_o), 0);
    lit("reset levels", int'({start_detect, finish_detect}), 0);
    lit("reset pulses", int'({start_pulse, finish_pulse, timeout_pulse}), 0);

    // Enable -> WAIT one cycle later
    rst = 0; en = 1;
    drive(0, 0, 0, 0);
    lit("enable wait state", int'(state_o), 1);
    lit("enable finish_detect", int'(finish_detect), 1);

    // Debounced start
    rep(3, 1, 200);
    lit("three bright stays wait", int'(state_o), 1);
    drive(1, 200, 200, 200);
    lit("fourth bright detect", int'(state_o), 2);
    lit("start_pulse on entry", int'(start_pulse), 1);
    lit("start_detect level", int'(start_detect), 1);
    drive(1, 128, 128, 128);
    lit("start_pulse one cycle", int'(start_pulse), 0);

    // Dark finish
    rep(3, 1, 10);
    lit("three dark stays detect", int'(state_o), 2);
    drive(1, 10, 10, 10);
    lit("finish_pulse", int'(finish_pulse), 1);
    lit("finish levels", int'({start_detect, finish_detect}), 1);

    // Broken run then valid gaps
    rep(3, 1, 200);
    drive(1, 100, 200, 200);
    rep(3, 1, 200);
    lit("broken run stays wait", int'(state_o), 1);
    drive(1, 128, 128, 128);
    for (int i = 0; i < 3; i++) begin
      drive(1, 200, 200, 200);
      drive(0, 200, 200, 200);
    end
    drive(1, 200, 200, 200);
    lit("gapped bright detect", int'(state_o), 2);

    // Exactly 31 is not dark; then timeout 16 cycles after entry
    rep(4, 1, 31);
    lit("value 31 not dark", int'(state_o), 2);
    rep(11, 1, 128);
    lit("no timeout at 15", int'(timeout_pulse), 0);
    drive(1, 128, 128, 128);
    lit("timeout_pulse at 16", int'(timeout_pulse), 1);
    lit("timeout returns wait", int'(state_o), 1);
    lit("no finish on timeout", int'(finish_pulse), 0);

    // Exactly 175 is not bright, 176 is
    rep(4, 1, 175);
    lit("value 175 not bright", int'(state_o), 1);
    rep(4, 1, 176);
    lit("value 176 bright", int'(state_o), 2);

    // Dark completion coincides with timeout
    rep(12, 1, 128);
    rep(4, 1, 10);
    lit("coincident finish_pulse", int'(finish_pulse), 1);
    lit("coincident timeout_pulse", int'(timeout_pulse), 0);

    // Abort via en
    rep(4, 1, 200);
    lit("abort setup detect", int'(state_o), 2);
    en = 0;
    drive(1, 10, 10, 10);
    lit("en low idle", int'(state_o), 0);
    lit("en low no pulses", int'({start_pulse, finish_pulse, timeout_pulse}), 0);
    en = 1;
    drive(1, 200, 200, 200);
    lit("re-enable wait", int'(state_o), 1);
    rep(3, 1, 200);
    lit("counter restarted", int'(state_o), 1);
    drive(1, 200, 200, 200);
    lit("re-enable detect", int'(state_o), 2);

    // Abort via rst
    rst = 1;
    drive(1, 10, 10, 10);
    lit("rst mid window idle", int'(state_o), 0);
    lit("rst no pulses", int'({start_pulse, finish_pulse, timeout_pulse, start_detect, finish_detect}), 0);
    rst = 0;
    drive(0, 0, 0, 0);
    lit("after rst wait", int'(state_o), 1);

    // Randomised traffic, checked every cycle by the reference
    for (int i = 0; i < 4000; i++) begin
      int cls, p;
      rst = ($urandom_range(299, 0) == 0);
      en  = ($urandom_range(99, 0) != 0);
      cls = $urandom_range(5, 0);
      p   = pick_level(cls);
      if (cls == 5)
        drive($urandom_range(3, 0) != 0, $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0));
      else
        drive($urandom_range(3, 0) != 0, p, (cls < 4) ? pick_level(cls) : p, (cls < 4) ? pick_level(cls) : p);
    end

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
